adder_sum_pipe: RTL and testbench

- Final pipelined section of the parallel-prefix adder; sits directly downstream of adder_stage5.
- Consumes stage-5 group generate/propagate vectors, which are prefixes within 16-bit blocks.
- Completes the remaining prefix levels (span 16, then 32, 64, ... up to DATA_W/2), resolves carries with carry-in, and produces sum, carry-out and flags.
- Two register stages with a valid/ready handshake so the ALU can stall it.

---
 rtl/adder_sum_pipe.sv | 179 +++++++++++++++++
 tb/tb_adder_sum_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_pipe.sv
// adder_sum_pipe: final prefix levels (span 16 .. DATA_W/2), carry resolution, sum/cout/flags.
// Latency: 2 cycles from input acceptance to out_valid; throughput one bundle per cycle.
// Backpressure: valid/ready; stages hold while out_ready is low, in_ready drops once both are full.
// Optional: zero_out/ovf_out/neg_out are built only when ADDER_SUM_FLAGS_EN is defined, else tied to 0.

`ifndef LEN_DATA
`define LEN_DATA 32
`endif

module adder_sum_pipe #(
    parameter int DATA_W = `LEN_DATA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] g_in,
    input  logic [DATA_W-1:0] p_in,
    input  logic [DATA_W-1:0] h_in,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum_out,
    output logic              cout_out,
    output logic              zero_out,
    output logic              ovf_out,
    output logic              neg_out
);

    // Bit-index width; also the number of prefix levels needed for full span.
    localparam int IW = $clog2(DATA_W);

    // Handshake
    logic w_adv1;
    logic w_adv2;
    logic w_acc;

    // Stage 1 (span-16 level) combinational result
    logic [DATA_W-1:0] w_g1;
    logic [DATA_W-1:0] w_p1;
    int                w_j1;

    // R1 registers
    logic              r_v1;
    logic [DATA_W-1:0] r_g1;
    logic [DATA_W-1:0] r_p1;
    logic [DATA_W-1:0] r_h1;
    logic              r_c1;

    // Stage 2 combinational result
    logic [DATA_W-1:0] w_g2;
    logic [DATA_W-1:0] w_p2;
    int                w_j2;
    logic [DATA_W-1:0] w_c;
    logic [DATA_W-1:0] w_sum;
    logic              w_cout;

    // R2 registers
    logic              r_v2;
    logic [DATA_W-1:0] r_sum;
    logic              r_cout;

    // A stage advances when it is empty or the stage below is advancing.
    assign w_adv2   = !r_v2 || out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1 && !rst && !flush;
    assign w_acc    = in_valid && in_ready;

    // Span-16 level: upper half of every 32-bit block combines with the top bit of its lower half.
    always_comb begin
        w_g1 = g_in;
        w_p1 = p_in;
        w_j1 = 0;
        for (int i = 16; i < DATA_W; i++) begin
            if (i[4]) begin
                w_j1 = (i | 15) & ~16;
                w_g1[IW'(i)] = g_in[IW'(i)] | (p_in[IW'(i)] & g_in[IW'(w_j1)]);
                w_p1[IW'(i)] = p_in[IW'(i)] & p_in[IW'(w_j1)];
            end
        end
    end

    // Remaining levels (span 32 .. DATA_W/2), updated in place: the partner bit j has bit L
    // cleared, so it is never modified at the level that reads it.
    always_comb begin
        w_g2 = r_g1;
        w_p2 = r_p1;
        w_j2 = 0;
        for (int lvl = 5; lvl < IW; lvl++) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (((i >> lvl) & 1) == 1) begin
                    w_j2 = (i | ((1 << lvl) - 1)) & ~(1 << lvl);
                    w_g2[IW'(i)] = w_g2[IW'(i)] | (w_p2[IW'(i)] & w_g2[IW'(w_j2)]);
                    w_p2[IW'(i)] = w_p2[IW'(i)] & w_p2[IW'(w_j2)];
                end
            end
        end
    end

    // Every G/P bit now spans [0..i]; fold in the carry-in to get the carry into each bit.
    assign w_c    = {w_g2[DATA_W-2:0] | (w_p2[DATA_W-2:0] & {(DATA_W-1){r_c1}}), r_c1};
    assign w_sum  = r_h1 ^ w_c;
    assign w_cout = w_g2[DATA_W-1] | (w_p2[DATA_W-1] & r_c1);

    // Pipeline valids and data; data registers load only alongside a valid being set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_g1   <= '0;
            r_p1   <= '0;
            r_h1   <= '0;
            r_c1   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= w_acc;
                if (w_acc) begin
                    r_g1 <= w_g1;
                    r_p1 <= w_p1;
                    r_h1 <= h_in;
                    r_c1 <= c_in;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_sum  <= w_sum;
                    r_cout <= w_cout;
                end
            end
        end
    end

    assign out_valid = r_v2;
    assign sum_out   = r_sum;
    assign cout_out  = r_cout;

`ifdef ADDER_SUM_FLAGS_EN
    logic w_zero;
    logic w_ovf;
    logic w_neg;
    logic r_zero;
    logic r_ovf;
    logic r_neg;

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign w_zero = ~|w_sum;
    assign w_ovf  = w_c[DATA_W-1] ^ w_cout;
    assign w_neg  = w_sum[DATA_W-1];

    // Flags travel in R2 alongside the sum they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_neg  <= 1'b0;
        end else if (!flush && w_adv2 && r_v1) begin
            r_zero <= w_zero;
            r_ovf  <= w_ovf;
            r_neg  <= w_neg;
        end
    end

    assign zero_out = r_zero;
    assign ovf_out  = r_ovf;
    assign neg_out  = r_neg;
`else
    assign zero_out = 1'b0;
    assign ovf_out  = 1'b0;
    assign neg_out  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_sum_pipe.sv
// Scoreboard bench: two instances (DATA_W=32 and 64) driven in lockstep from one operand stream.
// Expected results come from plain integer addition of the operands; g/p/h come from a
// per-16-bit-block group model of the upstream stages.
module tb_adder_sum_pipe;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        zero;
        logic        ovf;
        logic        neg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] ta;
    logic [63:0] tb_b;
    logic        tcin;
    logic [63:0] g64;
    logic [63:0] p64;
    logic [63:0] h64;
    logic        fix_rdy;
    logic        rand_mode;
    logic        rnd_rdy = 1'b1;
    logic        out_ready;

    logic        in_ready32, out_valid32, cout32, zero32, ovf32, neg32;
    logic [31:0] sum32;
    logic        in_ready64, out_valid64, cout64, zero64, ovf64, neg64;
    logic [63:0] sum64;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   base;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    assign out_ready = rand_mode ? rnd_rdy : fix_rdy;

    adder_sum_pipe #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .g_in(g64[31:0]), .p_in(p64[31:0]), .h_in(h64[31:0]), .c_in(tcin),
        .out_valid(out_valid32), .out_ready(out_ready),
        .sum_out(sum32), .cout_out(cout32),
        .zero_out(zero32), .ovf_out(ovf32), .neg_out(neg32)
    );

    adder_sum_pipe #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .g_in(g64), .p_in(p64), .h_in(h64), .c_in(tcin),
        .out_valid(out_valid64), .out_ready(out_ready),
        .sum_out(sum64), .cout_out(cout64),
        .zero_out(zero64), .ovf_out(ovf64), .neg_out(neg64)
    );

    // Upstream model: bit i is the group generate/propagate of bits [16*floor(i/16) .. i].
    function automatic void derive(input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] g, output logic [63:0] p);
        int          lo;
        int          len;
        logic [63:0] m;
        logic [63:0] as;
        logic [63:0] bs;
        logic [63:0] s;
        g = '0;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            lo   = (i / 16) * 16;
            len  = i - lo + 1;
            m    = (64'd1 << len) - 64'd1;
            as   = (a >> lo) & m;
            bs   = (b >> lo) & m;
            s    = as + bs;
            g[i] = s[len];
            p[i] = ((as ^ bs) == m);
        end
    endfunction

    always_comb begin
        derive(ta, tb_b, g64, p64);
        h64 = ta ^ tb_b;
    end

    // Reference: w-bit a + b + cin with signed-overflow rule from operand/result signs.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin);
        exp_t        e;
        logic [63:0] mask;
        logic [64:0] full;
        mask   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        full   = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
        e.sum  = full[63:0] & mask;
        e.cout = full[w];
        e.neg  = e.sum[w-1];
        e.zero = (e.sum == 64'd0);
        e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_res(input string tag, input exp_t e, input logic [63:0] s,
                           input logic co, input logic z, input logic o, input logic n);
        chk({tag, "_sum"}, s, e.sum);
        chk({tag, "_cout"}, {63'd0, co}, {63'd0, e.cout});
`ifdef ADDER_SUM_FLAGS_EN
        chk({tag, "_zero"}, {63'd0, z}, {63'd0, e.zero});
        chk({tag, "_ovf"}, {63'd0, o}, {63'd0, e.ovf});
        chk({tag, "_neg"}, {63'd0, n}, {63'd0, e.neg});
`else
        chk({tag, "_zero"}, {63'd0, z}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, o}, 64'd0);
        chk({tag, "_neg"}, {63'd0, n}, 64'd0);
`endif
    endtask

    // Stimulus side of the scoreboard: record the expected result of each accepted bundle.
    always @(negedge clk) begin
        if (in_valid === 1'b1 && in_ready32 === 1'b1) begin
            q32.push_back(model(32, ta, tb_b, tcin));
            n_acc++;
        end
        if (in_valid === 1'b1 && in_ready64 === 1'b1)
            q64.push_back(model(64, ta, tb_b, tcin));
    end

    // Monitor for the 32-bit instance; reset/flush discard whatever is still in flight.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid32 === 1'b1 && out_ready === 1'b1) begin
            if (q32.size() == 0) chk("unexpected_out32", {63'd0, out_valid32}, 64'd0);
            else begin
                e = q32.pop_front();
                cmp_res("res32", e, {32'd0, sum32}, cout32, zero32, ovf32, neg32);
            end
        end
        if (rst === 1'b1 || flush === 1'b1) q32.delete();
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid64 === 1'b1 && out_ready === 1'b1) begin
            if (q64.size() == 0) chk("unexpected_out64", {63'd0, out_valid64}, 64'd0);
            else begin
                e = q64.pop_front();
                cmp_res("res64", e, sum64, cout64, zero64, ovf64, neg64);
            end
        end
        if (rst === 1'b1 || flush === 1'b1) q64.delete();
    end

    // Random consumer stall pattern, used only while rand_mode is set.
    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one bundle and hold it until accepted (bounded).
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c);
        int n;
        n        = 0;
        ta       = a;
        tb_b     = b;
        tcin     = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready32 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", {63'd0, in_ready32}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Two-cycle latency check after a send into an empty, unstalled pipe.
    task automatic lat_check(input logic [31:0] exp_sum);
        @(negedge clk);
        chk("lat_cycle1_valid", {63'd0, out_valid32}, 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", {63'd0, out_valid32}, 64'd1);
        chk("lat_cycle2_sum", {32'd0, sum32}, {32'd0, exp_sum});
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        ta        = '0;
        tb_b      = '0;
        tcin      = 1'b0;
        fix_rdy   = 1'b1;
        rand_mode = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready32}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_sum", {32'd0, sum32}, 64'd0);
        chk("rst_cout", {63'd0, cout32}, 64'd0);
        chk("rst_flags", {61'd0, zero32, ovf32, neg32}, 64'd0);
        chk("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready32}, 64'd1);
        idle(1);

        // Directed corner sums
        send(64'hFFFF_FFFF, 64'd0, 1'b1);
        lat_check(32'h0000_0000);
        idle(2);
        send(64'h7FFF_FFFF, 64'd1, 1'b0);
        lat_check(32'h8000_0000);
        idle(2);

        // Back-pressure: consumer stalls while four bundles are offered
        fix_rdy = 1'b0;
        base    = n_acc;
        fork
            begin
                send(64'd1, 64'd1, 1'b0);
                send(64'd2, 64'd2, 1'b0);
                send(64'd3, 64'd3, 1'b0);
                send(64'd4, 64'd4, 1'b0);
            end
            begin
                for (int n = 0; n < 50 && n_acc < base + 2; n++) @(negedge clk);
                @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready", {63'd0, in_ready32}, 64'd0);
                    chk("bp_out_valid", {63'd0, out_valid32}, 64'd1);
                    chk("bp_hold_sum", {32'd0, sum32}, 64'd2);
                    @(negedge clk);
                end
                chk("bp_accepts_before_stall", 64'(n_acc - base), 64'd2);
                @(posedge clk);
                #1 fix_rdy = 1'b1;
            end
        join
        idle(6);
        chk("bp_drain32", 64'(q32.size()), 64'd0);

        // Flush kills two in-flight bundles
        fix_rdy = 1'b0;
        send(64'd7, 64'd7, 1'b0);
        send(64'd8, 64'd8, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready32}, 64'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        fix_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_out_valid", {63'd0, out_valid32}, 64'd0);
        end
        idle(1);
        send(64'd5, 64'd6, 1'b0);
        lat_check(32'h0000_000B);
        idle(2);

        // Reset with both stages full
        fix_rdy = 1'b0;
        send(64'd9, 64'd9, 1'b0);
        send(64'd10, 64'd10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, in_ready32}, 64'd0);
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("midrst_sum", {32'd0, sum32}, 64'd0);
        chk("midrst_cout", {63'd0, cout32}, 64'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        fix_rdy = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_after", {63'd0, in_ready32}, 64'd1);
        idle(1);

        // Wide carries through the span-32 level
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        idle(4);

        // Random operands with random consumer stalls
        rand_mode = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            logic [63:0] a;
            logic [63:0] b;
            int          sel;
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel == 0) b = ~a;
            if (sel == 1) a = 64'hFFFF_FFFF_FFFF_FFFF;
            if (sel == 2) b = 64'd0;
            send(a, b, 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        fix_rdy   = 1'b1;
        idle(20);
        chk("final_drain32", 64'(q32.size()), 64'd0);
        chk("final_drain64", 64'(q64.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
